// File: rtl/ec_stripe_sequencer.sv
// Erasure-code stripe sequencer: pops k data chunks, then for each of m parity rows
// fetches one bitmatrix column, hands it to the engine, strobes a compute and pushes a result.
module ec_stripe_sequencer #(
  parameter int W             = 8,
  parameter int K_MAX         = 8,
  parameter int M_MAX         = 4,
  parameter int BM_MEM_ADDR_W = 8,
  parameter int STRIPE_CNT_W  = 16,
  localparam int BM_COL_W     = W * W * K_MAX,
  localparam int KW           = $clog2(K_MAX + 1),
  localparam int MW           = $clog2(M_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [KW-1:0]            cfg_k,
  input  logic [MW-1:0]            cfg_m,
  input  logic [STRIPE_CNT_W-1:0]  cfg_stripes,
  input  logic [BM_MEM_ADDR_W-1:0] cfg_bm_base,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic [STRIPE_CNT_W-1:0]  stripe_cnt,
  output logic                     bm_rd_req,
  output logic [BM_MEM_ADDR_W-1:0] bm_rd_addr,
  input  logic [BM_COL_W-1:0]      bm_rd_data,
  input  logic                     bm_rd_data_val,
  output logic [BM_COL_W-1:0]      col_data,
  output logic                     col_val,
  input  logic                     col_rdy,
  output logic                     eng_rst,
  output logic                     eng_calc_en,
  input  logic                     eng_empty,
  input  logic                     inbuff_empty,
  output logic                     inbuff_rd_en,
  input  logic                     outbuff_full,
  output logic                     outbuff_wr_en
);

  typedef enum logic [3:0] {
    IDLE, ENG_RST, READ, FETCH, WAIT_BM, PRESENT, CALC, WRITE, DRAIN, DONE
  } state_t;

  localparam logic [KW-1:0] K_MAX_C = KW'(K_MAX);
  localparam logic [MW-1:0] M_MAX_C = MW'(M_MAX);

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     r_eng_rst_2nd;
  logic                     r_abort_rst;
  logic                     r_cfg_err;
  logic [KW-1:0]            r_k;
  logic [MW-1:0]            r_m;
  logic [STRIPE_CNT_W-1:0]  r_stripes;
  logic [BM_MEM_ADDR_W-1:0] r_base;
  logic [STRIPE_CNT_W-1:0]  r_stripe_cnt;
  logic [KW-1:0]            r_pop_cnt;
  logic [MW-1:0]            r_row;
  logic [BM_COL_W-1:0]      r_col_data;

  logic                     w_cfg_valid;
  logic                     w_cfg_bad;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_rd_req;
  logic                     w_calc;
  logic                     w_col_val;
  logic                     w_last_pop;
  logic                     w_last_row;
  logic [STRIPE_CNT_W-1:0]  w_stripe_inc;

  assign w_cfg_valid  = (cfg_k != '0) && (cfg_k <= K_MAX_C) &&
                        (cfg_m != '0) && (cfg_m <= M_MAX_C) &&
                        (cfg_stripes != '0);
  assign w_last_pop   = (r_pop_cnt == r_k - 1'b1);
  assign w_last_row   = (r_row == r_m - 1'b1);
  assign w_stripe_inc = r_stripe_cnt + 1'b1;

  // NOTE: every signal written here gets a default before the case so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_cfg_bad    = 1'b0;
    w_pop        = 1'b0;
    w_push       = 1'b0;
    w_rd_req     = 1'b0;
    w_calc       = 1'b0;
    w_col_val    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          if (w_cfg_valid) w_next_state = ENG_RST;
          else             w_cfg_bad    = 1'b1;
        end
      end
      ENG_RST: if (r_eng_rst_2nd) w_next_state = READ;
      READ: begin
        w_pop = !inbuff_empty;
        if (w_pop && w_last_pop) w_next_state = FETCH;
      end
      FETCH: begin
        w_rd_req     = 1'b1;
        w_next_state = WAIT_BM;
      end
      WAIT_BM: if (bm_rd_data_val) w_next_state = PRESENT;
      PRESENT: begin
        w_col_val = 1'b1;
        if (col_rdy) w_next_state = CALC;
      end
      CALC: begin
        w_calc       = 1'b1;
        w_next_state = WRITE;
      end
      WRITE: begin
        w_push = !outbuff_full;
        if (w_push) begin
          if (!w_last_row)                  w_next_state = FETCH;
          else if (w_stripe_inc < r_stripes) w_next_state = READ;
          else                              w_next_state = DRAIN;
        end
      end
      DRAIN:   if (eng_empty) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase

    // An abort cycle must leave no side effects on the buffers, memory or engine.
    if (abort && (r_state != IDLE)) begin
      w_next_state = IDLE;
      w_pop        = 1'b0;
      w_push       = 1'b0;
      w_rd_req     = 1'b0;
      w_calc       = 1'b0;
      w_col_val    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_eng_rst_2nd <= 1'b0;
      r_abort_rst   <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_k           <= '0;
      r_m           <= '0;
      r_stripes     <= '0;
      r_base        <= '0;
      r_stripe_cnt  <= '0;
      r_pop_cnt     <= '0;
      r_row         <= '0;
      r_col_data    <= '0;
    end else begin
      r_state       <= w_next_state;
      r_eng_rst_2nd <= (r_state == ENG_RST) && (w_next_state == ENG_RST);
      r_abort_rst   <= abort && (r_state != IDLE);
      r_cfg_err     <= w_cfg_bad;

      if ((r_state == IDLE) && (w_next_state == ENG_RST)) begin
        r_k          <= cfg_k;
        r_m          <= cfg_m;
        r_stripes    <= cfg_stripes;
        r_base       <= cfg_bm_base;
        r_stripe_cnt <= '0;
        r_pop_cnt    <= '0;
        r_row        <= '0;
      end

      if (w_pop) begin
        r_pop_cnt <= w_last_pop ? '0 : r_pop_cnt + 1'b1;
        if (w_last_pop) r_row <= '0;
      end

      if ((r_state == WAIT_BM) && (w_next_state == PRESENT)) r_col_data <= bm_rd_data;

      if (w_push) begin
        if (w_last_row) begin
          r_row        <= '0;
          r_stripe_cnt <= w_stripe_inc;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
  assign cfg_err       = r_cfg_err;
  assign stripe_cnt    = r_stripe_cnt;
  assign bm_rd_req     = w_rd_req;
  assign bm_rd_addr    = r_base + BM_MEM_ADDR_W'(r_row);
  assign col_data      = r_col_data;
  assign col_val       = w_col_val;
  assign eng_rst       = rst || (r_state == ENG_RST) || r_abort_rst;
  assign eng_calc_en   = w_calc;
  assign inbuff_rd_en  = w_pop;
  assign outbuff_wr_en = w_push;

endmodule

// File: tb/tb_ec_stripe_sequencer.sv
// Bench for ec_stripe_sequencer: config table, event-trace reference model, random
// handshake stalls, plus directed abort, drain-delay and mid-job reset sequences.
module tb_ec_stripe_sequencer;

  localparam int BM_COL_W = 512;

  localparam logic [31:0] EV_POP  = 32'h1000_0000;
  localparam logic [31:0] EV_RD   = 32'h2000_0000;
  localparam logic [31:0] EV_COL  = 32'h3000_0000;
  localparam logic [31:0] EV_CALC = 32'h4000_0000;
  localparam logic [31:0] EV_PUSH = 32'h5000_0000;
  localparam logic [31:0] EV_DONE = 32'h6000_0000;

  logic                clk = 1'b0;
  logic                rst, start, abort;
  logic [3:0]          cfg_k;
  logic [2:0]          cfg_m;
  logic [15:0]         cfg_stripes;
  logic [7:0]          cfg_bm_base;
  logic                busy, done, cfg_err;
  logic [15:0]         stripe_cnt;
  logic                bm_rd_req;
  logic [7:0]          bm_rd_addr;
  logic [BM_COL_W-1:0] bm_rd_data;
  logic                bm_rd_data_val;
  logic [BM_COL_W-1:0] col_data;
  logic                col_val, col_rdy;
  logic                eng_rst, eng_calc_en, eng_empty;
  logic                inbuff_empty, inbuff_rd_en;
  logic                outbuff_full, outbuff_wr_en;

  ec_stripe_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_k(cfg_k), .cfg_m(cfg_m), .cfg_stripes(cfg_stripes), .cfg_bm_base(cfg_bm_base),
    .busy(busy), .done(done), .cfg_err(cfg_err), .stripe_cnt(stripe_cnt),
    .bm_rd_req(bm_rd_req), .bm_rd_addr(bm_rd_addr), .bm_rd_data(bm_rd_data),
    .bm_rd_data_val(bm_rd_data_val), .col_data(col_data), .col_val(col_val),
    .col_rdy(col_rdy), .eng_rst(eng_rst), .eng_calc_en(eng_calc_en),
    .eng_empty(eng_empty), .inbuff_empty(inbuff_empty), .inbuff_rd_en(inbuff_rd_en),
    .outbuff_full(outbuff_full), .outbuff_wr_en(outbuff_wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  k;
    logic [2:0]  m;
    logic [15:0] stripes;
    logic [7:0]  base;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] q_obs [$];
  logic [31:0] q_exp [$];
  int done_cnt, err_cnt, eng_rst_cycles, viol_pop, viol_push, viol_stab;

  // Environment knobs and state shared between monitor and driver.
  bit   stall = 0;
  bit   eng_hold0 = 0;
  bit   mem_block = 0;
  bit   mem_pend = 0;
  logic [7:0] mem_addr = '0;
  int   mem_lat = 0;
  int   col_hold_cnt = 0;
  int   full_cnt = 0;
  bit   prev_hold = 0;
  logic [BM_COL_W-1:0] prev_data = '0;
  logic [7:0] last_rd_addr = '0;

  function automatic logic [BM_COL_W-1:0] pat(input logic [7:0] a);
    return {32{a, a ^ 8'h5A}};
  endfunction

  task automatic check(input string name, input logic [BM_COL_W-1:0] act,
                       input logic [BM_COL_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observed event trace and protocol-violation tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      col_hold_cnt = 0;
      full_cnt     = 0;
      prev_hold    = 0;
    end else begin
      if (inbuff_rd_en) begin
        q_obs.push_back(EV_POP);
        if (inbuff_empty) viol_pop++;
      end
      if (bm_rd_req) begin
        q_obs.push_back(EV_RD | {24'h0, bm_rd_addr});
        last_rd_addr = bm_rd_addr;
        mem_pend     = 1;
        mem_addr     = bm_rd_addr;
        mem_lat      = stall ? int'($urandom_range(0, 3)) : 0;
      end
      if (prev_hold && (!col_val || col_data != prev_data)) viol_stab++;
      if (col_val && col_rdy) begin
        q_obs.push_back(EV_COL);
        check("col_data_at_accept", col_data, pat(last_rd_addr));
      end
      prev_hold    = col_val && !col_rdy;
      prev_data    = col_data;
      col_hold_cnt = (col_val && !col_rdy) ? col_hold_cnt + 1 : 0;
      if (eng_calc_en) begin
        q_obs.push_back(EV_CALC);
        full_cnt = 3;
      end else if (full_cnt > 0) begin
        full_cnt--;
      end
      if (outbuff_wr_en) begin
        q_obs.push_back(EV_PUSH);
        if (outbuff_full) viol_push++;
      end
      if (done) begin
        q_obs.push_back(EV_DONE);
        done_cnt++;
      end
      if (cfg_err) err_cnt++;
      if (eng_rst) eng_rst_cycles++;
    end
  end

  // Handshake and bitmatrix-memory responder, driven just after the active edge.
  always @(posedge clk) begin
    #1;
    inbuff_empty   = stall ? ($urandom_range(0, 1) == 1) : 1'b0;
    col_rdy        = stall ? (col_hold_cnt >= 5) : 1'b1;
    outbuff_full   = stall ? (full_cnt > 0) : 1'b0;
    eng_empty      = eng_hold0 ? 1'b0 : (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
    bm_rd_data_val = 1'b0;
    if (mem_pend) begin
      if (!mem_block) begin
        if (mem_lat == 0) begin
          bm_rd_data_val = 1'b1;
          bm_rd_data     = pat(mem_addr);
          mem_pend       = 0;
        end else begin
          mem_lat--;
        end
      end
    end else if (stall && $urandom_range(0, 7) == 0) begin
      bm_rd_data_val = 1'b1;
      bm_rd_data     = {16{$urandom()}};
    end
  end

  task automatic build_exp(input vec_t v);
    q_exp.delete();
    for (int s = 0; s < int'(v.stripes); s++) begin
      for (int i = 0; i < int'(v.k); i++) q_exp.push_back(EV_POP);
      for (int r = 0; r < int'(v.m); r++) begin
        q_exp.push_back(EV_RD | {24'h0, 8'(int'(v.base) + r)});
        q_exp.push_back(EV_COL);
        q_exp.push_back(EV_CALC);
        q_exp.push_back(EV_PUSH);
      end
    end
    q_exp.push_back(EV_DONE);
  endtask

  task automatic clear_stats();
    q_obs.delete();
    done_cnt = 0; err_cnt = 0; eng_rst_cycles = 0;
    viol_pop = 0; viol_push = 0; viol_stab = 0;
  endtask

  task automatic pulse_start(input logic [3:0] k, input logic [2:0] m,
                             input logic [15:0] s, input logic [7:0] b);
    @(posedge clk); #1;
    cfg_k = k; cfg_m = m; cfg_stripes = s; cfg_bm_base = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    int n;
    int bad;
    bit rs;
    clear_stats();
    pulse_start(v.k, v.m, v.stripes, v.base);
    @(negedge clk);
    check("cfg_err_after_start", cfg_err, v.exp_err);
    check("busy_after_start", busy, !v.exp_err);
    if (v.exp_err) begin
      @(negedge clk);
      check("cfg_err_single_pulse", cfg_err, 1'b0);
      check("busy_stays_low", busy, 1'b0);
      return;
    end
    n = 0;
    while (busy && n < 20000) begin
      rs = stall && !done && ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      start = rs;
      if (rs) begin
        cfg_k = 4'($urandom); cfg_m = 3'($urandom);
        cfg_stripes = 16'($urandom); cfg_bm_base = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("job_finished_in_budget", busy, 1'b0);
    build_exp(v);
    bad = -1;
    for (int i = 0; i < q_exp.size(); i++)
      if (bad < 0 && (i >= q_obs.size() || q_obs[i] != q_exp[i])) bad = i;
    check("trace_len", q_obs.size(), q_exp.size());
    check("trace_match", bad < 0, 1'b1);
    if (bad >= 0 && bad < q_obs.size())
      $display("  first trace difference at event %0d: got %h expected %h", bad, q_obs[bad], q_exp[bad]);
    check("stripe_cnt_final", stripe_cnt, v.stripes);
    check("done_pulses", done_cnt, 1);
    check("eng_rst_cycles", eng_rst_cycles, 2);
    check("no_cfg_err_in_job", err_cnt, 0);
    check("no_pop_when_empty", viol_pop, 0);
    check("no_push_when_full", viol_push, 0);
    check("col_data_stable", viol_stab, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok_hold;
    logic [BM_COL_W-1:0] col_snap;

    vecs[0] = '{k: 4'd4, m: 3'd2, stripes: 16'd3, base: 8'h10, exp_err: 1'b0};
    vecs[1] = '{k: 4'd0, m: 3'd2, stripes: 16'd3, base: 8'h00, exp_err: 1'b1};
    vecs[2] = '{k: 4'd4, m: 3'd5, stripes: 16'd3, base: 8'h00, exp_err: 1'b1};
    vecs[3] = '{k: 4'd9, m: 3'd1, stripes: 16'd1, base: 8'h00, exp_err: 1'b1};
    vecs[4] = '{k: 4'd2, m: 3'd0, stripes: 16'd1, base: 8'h00, exp_err: 1'b1};
    vecs[5] = '{k: 4'd2, m: 3'd2, stripes: 16'd0, base: 8'h00, exp_err: 1'b1};
    vecs[6] = '{k: 4'd1, m: 3'd2, stripes: 16'd1, base: 8'hFF, exp_err: 1'b0};
    vecs[7] = '{k: 4'd8, m: 3'd4, stripes: 16'd2, base: 8'hFE, exp_err: 1'b0};
    vecs[8] = '{k: 4'd1, m: 3'd1, stripes: 16'd1, base: 8'h00, exp_err: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_k = '0; cfg_m = '0; cfg_stripes = '0; cfg_bm_base = '0;
    bm_rd_data = '0; bm_rd_data_val = 1'b0; col_rdy = 1'b1; eng_empty = 1'b1;
    inbuff_empty = 1'b1; outbuff_full = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_eng_rst", eng_rst, 1'b1);
    check("rst_strobes", {bm_rd_req, col_val, eng_calc_en, inbuff_rd_en, outbuff_wr_en}, 5'b0);
    check("rst_stripe_cnt", stripe_cnt, 16'd0);
    check("rst_bm_rd_addr", bm_rd_addr, 8'd0);
    check("rst_col_data", col_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("eng_rst_released", eng_rst, 1'b0);

    // All handshakes ready: exact traces for every config row.
    stall = 0;
    for (int i = 0; i < 9; i++) run_job(vecs[i]);

    // Random stalls, spurious read data and start pulses while busy.
    stall = 1;
    for (int pass = 0; pass < 3; pass++)
      for (int i = 0; i < 9; i++) run_job(vecs[i]);
    stall = 0;

    // start and abort together in IDLE start nothing.
    clear_stats();
    @(posedge clk); #1;
    cfg_k = 4'd2; cfg_m = 3'd1; cfg_stripes = 16'd1; cfg_bm_base = 8'h00;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle_busy", busy, 1'b0);
    check("start_abort_idle_cfg_err", cfg_err, 1'b0);

    // Drain waits for the engine pipeline to empty.
    clear_stats();
    eng_hold0 = 1;
    pulse_start(4'd1, 3'd1, 16'd1, 8'h20);
    n = 0;
    do begin @(negedge clk); n++; end while (!outbuff_wr_en && n < 100);
    check("drain_push_seen", outbuff_wr_en, 1'b1);
    ok_hold = 1;
    repeat (10) begin
      @(negedge clk);
      if (!busy || done) ok_hold = 0;
    end
    check("drain_holds_busy", ok_hold, 1'b1);
    check("drain_no_done_yet", done_cnt, 0);
    eng_hold0 = 0;
    @(negedge clk);
    check("done_not_in_empty_cycle", done, 1'b0);
    @(negedge clk);
    check("done_after_empty", done, 1'b1);
    @(negedge clk);
    check("idle_after_done", busy, 1'b0);

    // Abort while waiting on the first bitmatrix read of stripe 2.
    clear_stats();
    pulse_start(4'd2, 3'd2, 16'd3, 8'h40);
    n = 0;
    do begin @(negedge clk); n++; end while (!(bm_rd_req && stripe_cnt == 16'd1) && n < 500);
    check("abort_reached_stripe2", bm_rd_req && stripe_cnt == 16'd1, 1'b1);
    mem_block = 1;
    col_snap  = col_data;
    check("col_before_abort", col_snap, pat(8'h41));
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_eng_rst", eng_rst, 1'b1);
    check("abort_stripe_cnt", stripe_cnt, 16'd1);
    mem_block = 0;
    @(negedge clk);
    check("abort_eng_rst_one_cycle", eng_rst, 1'b0);
    @(negedge clk);
    check("late_val_ignored_data", col_data, col_snap);
    check("late_val_ignored_state", {busy, col_val}, 2'b00);
    check("abort_no_done", done_cnt, 0);
    check("abort_eng_rst_total", eng_rst_cycles, 3);

    // Reset mid-job with a read outstanding discards everything.
    clear_stats();
    pulse_start(4'd2, 3'd1, 16'd3, 8'h80);
    n = 0;
    do begin @(negedge clk); n++; end while (!(bm_rd_req && stripe_cnt == 16'd1) && n < 500);
    check("rst_reached_stripe2", bm_rd_req && stripe_cnt == 16'd1, 1'b1);
    mem_block = 1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("eng_rst_during_rst", eng_rst, 1'b1);
    mem_pend  = 0;
    mem_block = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_stripe_cnt", stripe_cnt, 16'd0);
    check("midrst_col_data", col_data, '0);
    check("midrst_bm_rd_addr", bm_rd_addr, 8'd0);
    check("midrst_eng_rst", eng_rst, 1'b0);
    run_job(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
